multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 74 +++++++
 tb/tb_multicycle_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle CPU control FSM (clk, reset, opcode, zero, mem_ready -> datapath controls, state, instr_done, illegal_op, retired_count)
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        memto_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [15:0] retired_count
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_READ = 4'd4,
    MEM_WB = 4'd5, MEM_WRITE = 4'd6, EXECUTE = 4'd7, ALU_WB = 4'd8, BRANCH = 4'd9,
    JUMP = 4'd10, ADDI_EX = 4'd11, ADDI_WB = 4'd12
  } state_t;
  state_t cur;
  logic unused_zero;
  assign unused_zero = zero;
  assign state = cur;
  always_ff @(posedge clk)
    if (reset) begin
      cur <= IDLE;
      retired_count <= '0;
    end else begin
      if (instr_done) retired_count <= retired_count + 16'd1;
      case (cur)
        IDLE:      cur <= FETCH;
        FETCH:     cur <= mem_ready ? DECODE : FETCH;
        DECODE:    cur <= (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                          opcode == OP_R    ? EXECUTE :
                          opcode == OP_BEQ  ? BRANCH  :
                          opcode == OP_J    ? JUMP    :
                          opcode == OP_ADDI ? ADDI_EX : FETCH;
        MEM_ADDR:  cur <= opcode == OP_SW ? MEM_WRITE : MEM_READ;
        MEM_READ:  cur <= mem_ready ? MEM_WB : MEM_READ;
        MEM_WRITE: cur <= mem_ready ? FETCH : MEM_WRITE;
        EXECUTE:   cur <= ALU_WB;
        ADDI_EX:   cur <= ADDI_WB;
        default:   cur <= FETCH;
      endcase
    end
  assign mem_read      = cur == FETCH || cur == MEM_READ;
  assign ir_write      = cur == FETCH && mem_ready;
  assign pc_write      = (cur == FETCH && mem_ready) || cur == JUMP;
  assign pc_write_cond = cur == BRANCH;
  assign mem_write     = cur == MEM_WRITE;
  assign reg_write     = cur == MEM_WB || cur == ALU_WB || cur == ADDI_WB;
  assign reg_dst       = cur == ALU_WB;
  assign memto_reg     = cur == MEM_WB;
  assign alu_src_a     = cur inside {MEM_ADDR, EXECUTE, BRANCH, ADDI_EX};
  assign alu_src_b     = cur == FETCH ? 2'b01 : cur == DECODE ? 2'b11 :
                         (cur == MEM_ADDR || cur == ADDI_EX) ? 2'b10 : 2'b00;
  assign alu_op        = cur == EXECUTE ? 2'b10 : cur == BRANCH ? 2'b01 : 2'b00;
  assign pc_source     = cur == BRANCH ? 2'b01 : cur == JUMP ? 2'b10 : 2'b00;
  assign instr_done    = cur inside {MEM_WB, ALU_WB, BRANCH, JUMP, ADDI_WB} ||
                         (cur == MEM_WRITE && mem_ready);
  assign illegal_op    = cur == DECODE && !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
  logic clk = 0, reset = 1, zero = 0, mem_ready = 0;
  logic [5:0] opcode = 0;
  logic pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, reg_dst, memto_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic instr_done, illegal_op;
  logic [15:0] retired_count;
  logic [16:0] ctl;
  int checks = 0, errors = 0;
  localparam logic [16:0] C_ZERO   = 17'b0;
  localparam logic [16:0] C_FETCH  = 17'b1_0_1_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] C_FSTALL = 17'b0_0_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [16:0] C_DECILL = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [16:0] C_MADDR  = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] C_MREAD  = 17'b0_0_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [16:0] C_MWSTL  = 17'b0_0_0_0_1_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] C_MWDONE = 17'b0_0_0_0_1_0_0_0_0_00_00_00_1_0;
  localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [16:0] C_ADDIWB = 17'b0_0_0_0_0_1_0_0_0_00_00_00_1_0;
  assign ctl = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, reg_dst,
                memto_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};
  always #5 clk = ~clk;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .memto_reg(memto_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .instr_done(instr_done), .illegal_op(illegal_op), .retired_count(retired_count)
  );
  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset state got %0d exp 0", state); end
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL reset ctl got %b exp %b", ctl, C_ZERO); end
    checks++; if (retired_count !== 16'd0) begin errors++; $display("FAIL reset count got %0d exp 0", retired_count); end
    reset = 0;
    @(negedge clk);
    checks++; if (state !== 4'd0 || ctl !== C_ZERO) begin errors++; $display("FAIL post_reset got state %0d ctl %b exp 0", state, ctl); end
    @(posedge clk); #1;
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL first_fetch state got %0d exp 1", state); end
  endtask
  task automatic test_lw;
    logic [3:0]  es [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [16:0] ec [5] = '{C_FETCH, C_DEC, C_MADDR, C_MREAD, C_MWB};
    opcode = 6'b100011; mem_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (state !== es[k]) begin errors++; $display("FAIL lw state[%0d] got %0d exp %0d", k, state, es[k]); end
      checks++; if (ctl !== ec[k]) begin errors++; $display("FAIL lw ctl[%0d] got %b exp %b", k, ctl, ec[k]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL lw end state got %0d exp 1", state); end
    checks++; if (retired_count !== 16'd1) begin errors++; $display("FAIL lw count got %0d exp 1", retired_count); end
  endtask
  task automatic test_sw;
    logic [3:0]  es [7] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd6, 4'd6};
    logic [16:0] ec [7] = '{C_FETCH, C_DEC, C_MADDR, C_MWSTL, C_MWSTL, C_MWSTL, C_MWDONE};
    logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode = 6'b101011;
    for (int k = 0; k < 7; k++) begin
      mem_ready = mr[k];
      @(negedge clk);
      checks++; if (state !== es[k]) begin errors++; $display("FAIL sw state[%0d] got %0d exp %0d", k, state, es[k]); end
      checks++; if (ctl !== ec[k]) begin errors++; $display("FAIL sw ctl[%0d] got %b exp %b", k, ctl, ec[k]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL sw end state got %0d exp 1", state); end
    checks++; if (retired_count !== 16'd2) begin errors++; $display("FAIL sw count got %0d exp 2", retired_count); end
  endtask
  task automatic test_rtype_addi;
    logic [3:0]  es [8] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1, 4'd2, 4'd11, 4'd12};
    logic [16:0] ec [8] = '{C_FETCH, C_DEC, C_EXEC, C_ALUWB, C_FETCH, C_DEC, C_MADDR, C_ADDIWB};
    mem_ready = 1;
    for (int k = 0; k < 8; k++) begin
      opcode = k < 4 ? 6'b000000 : 6'b001000;
      @(negedge clk);
      checks++; if (state !== es[k]) begin errors++; $display("FAIL alu state[%0d] got %0d exp %0d", k, state, es[k]); end
      checks++; if (ctl !== ec[k]) begin errors++; $display("FAIL alu ctl[%0d] got %b exp %b", k, ctl, ec[k]); end
      @(posedge clk); #1;
    end
    checks++; if (retired_count !== 16'd4) begin errors++; $display("FAIL alu count got %0d exp 4", retired_count); end
  endtask
  task automatic test_branch_jump;
    logic [3:0]  es [9] = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10};
    logic [16:0] ec [9] = '{C_FETCH, C_DEC, C_BRANCH, C_FETCH, C_DEC, C_BRANCH, C_FETCH, C_DEC, C_JUMP};
    mem_ready = 1;
    for (int k = 0; k < 9; k++) begin
      opcode = k < 6 ? 6'b000100 : 6'b000010;
      zero = k < 3;
      @(negedge clk);
      checks++; if (state !== es[k]) begin errors++; $display("FAIL bj state[%0d] got %0d exp %0d", k, state, es[k]); end
      checks++; if (ctl !== ec[k]) begin errors++; $display("FAIL bj ctl[%0d] got %b exp %b", k, ctl, ec[k]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL bj end state got %0d exp 1", state); end
    checks++; if (retired_count !== 16'd7) begin errors++; $display("FAIL bj count got %0d exp 7", retired_count); end
  endtask
  task automatic test_illegal;
    logic [3:0]  es [2] = '{4'd1, 4'd2};
    logic [16:0] ec [2] = '{C_FETCH, C_DECILL};
    opcode = 6'b111111; mem_ready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (state !== es[k]) begin errors++; $display("FAIL ill state[%0d] got %0d exp %0d", k, state, es[k]); end
      checks++; if (ctl !== ec[k]) begin errors++; $display("FAIL ill ctl[%0d] got %b exp %b", k, ctl, ec[k]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL ill end state got %0d exp 1", state); end
    checks++; if (retired_count !== 16'd7) begin errors++; $display("FAIL ill count got %0d exp 7", retired_count); end
  endtask
  task automatic test_stall_lw;
    logic [3:0]  es [8] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5};
    logic [16:0] ec [8] = '{C_FSTALL, C_FSTALL, C_FETCH, C_DEC, C_MADDR, C_MREAD, C_MREAD, C_MWB};
    logic        mr [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b100011;
    for (int k = 0; k < 8; k++) begin
      mem_ready = mr[k];
      @(negedge clk);
      checks++; if (state !== es[k]) begin errors++; $display("FAIL stall state[%0d] got %0d exp %0d", k, state, es[k]); end
      checks++; if (ctl !== ec[k]) begin errors++; $display("FAIL stall ctl[%0d] got %b exp %b", k, ctl, ec[k]); end
      @(posedge clk); #1;
    end
    checks++; if (retired_count !== 16'd8) begin errors++; $display("FAIL stall count got %0d exp 8", retired_count); end
  endtask
  task automatic test_reset_mid;
    opcode = 6'b100011; mem_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 0;
    @(negedge clk);
    checks++; if (state !== 4'd4) begin errors++; $display("FAIL rmid pre state got %0d exp 4", state); end
    reset = 1;
    @(posedge clk); #1;
    checks++; if (state !== 4'd0 || ctl !== C_ZERO) begin errors++; $display("FAIL rmid state %0d ctl %b exp 0", state, ctl); end
    checks++; if (retired_count !== 16'd0) begin errors++; $display("FAIL rmid count got %0d exp 0", retired_count); end
    reset = 0;
    @(negedge clk);
    checks++; if (state !== 4'd0 || ctl !== C_ZERO) begin errors++; $display("FAIL rmid after state %0d ctl %b exp 0", state, ctl); end
    @(posedge clk); #1;
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL rmid fetch state got %0d exp 1", state); end
  endtask
  task automatic test_wrap;
    opcode = 6'b000010; mem_ready = 0;
    force dut.retired_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.retired_count;
    checks++; if (retired_count !== 16'hFFFF) begin errors++; $display("FAIL wrap preload got %h exp ffff", retired_count); end
    mem_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL wrap state got %0d exp 1", state); end
    checks++; if (retired_count !== 16'h0000) begin errors++; $display("FAIL wrap count got %h exp 0000", retired_count); end
  endtask
  initial begin
    test_reset;
    test_lw;
    test_sw;
    test_rtype_addi;
    test_branch_jump;
    test_illegal;
    test_stall_lw;
    test_reset_mid;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
